// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store encodings, LSU FSM state type and access-size helper.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // Illegal codes report 4 so they never look smaller than a real access.
  function automatic logic [2:0] size_bytes(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return 3'd1;
      F3_H, F3_HU: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational access checker: fault detection, store byte enables and load extension.
// Purely combinational; no state, no backpressure.
module lsu_align
  import rv32i_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0020_0000,
  parameter logic [31:0] DEPTH_BYTES = 32'h0005_0000
) (
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] rword_i,
  output logic        fault_o,
  output logic [3:0]  be_o,
  output logic [31:0] rdata_o
);

  logic [2:0]  size;
  logic        illegal;
  logic        misalign;
  logic        range_err;
  logic [32:0] addr_x;
  logic [32:0] end_x;
  logic [32:0] lim_x;

  always_comb begin
    size = size_bytes(funct3_i);
    if (we_i) begin
      illegal = !(funct3_i inside {F3_B, F3_H, F3_W});
    end else begin
      illegal = !(funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end
    misalign = ((size == 3'd2) && addr_i[0]) ||
               ((size == 3'd4) && (addr_i[1:0] != 2'b00));
    // 33-bit arithmetic so an access near 0xFFFFFFFF cannot wrap into range.
    addr_x    = {1'b0, addr_i};
    end_x     = addr_x + {30'd0, size};
    lim_x     = {1'b0, BASE_ADDR} + {1'b0, DEPTH_BYTES};
    range_err = (addr_x < {1'b0, BASE_ADDR}) || (end_x > lim_x);
    fault_o   = illegal || misalign || range_err;

    case (size)
      3'd1:    be_o = 4'b0001;
      3'd2:    be_o = 4'b0011;
      default: be_o = 4'b1111;
    endcase

    case (funct3_i)
      F3_B:    rdata_o = {{24{rword_i[7]}}, rword_i[7:0]};
      F3_H:    rdata_o = {{16{rword_i[15]}}, rword_i[15:0]};
      F3_BU:   rdata_o = {24'd0, rword_i[7:0]};
      F3_HU:   rdata_o = {16'd0, rword_i[15:0]};
      default: rdata_o = rword_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem.sv
// Data-memory controller: valid/ready load/store requests, WAIT_STATES+1 cycle registered response.
// One request in flight; req_ready drops from accept until the response is consumed.
module lsu_mem
  import rv32i_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0020_0000,
  parameter logic [31:0] DEPTH_BYTES = 32'h0005_0000,
  parameter int          WAIT_STATES = 0,
  parameter int          ERRCNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

  lsu_state_e          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic                rsp_valid_q;
  logic [31:0]         rsp_rdata_q;
  logic                rsp_err_q;
  logic [ERRCNT_W-1:0] err_q;
  logic                enter_resp;

  logic [7:0]          mem_q [0:DEPTH_BYTES-1];

  logic                sel_we;
  logic [2:0]          sel_f3;
  logic [31:0]         sel_addr;
  logic [31:0]         sel_wdata;
  logic [31:0]         off;
  logic [AW-1:0]       idx [4];
  logic [31:0]         rword;
  logic                fault;
  logic [3:0]          be;
  logic [31:0]         ext_rdata;
  logic                mem_wr;

  // With no wait states the response is formed on the accept edge, so use the live request.
  assign sel_we    = (state_q == ST_IDLE) ? req_we     : we_q;
  assign sel_f3    = (state_q == ST_IDLE) ? req_funct3 : f3_q;
  assign sel_addr  = (state_q == ST_IDLE) ? req_addr   : addr_q;
  assign sel_wdata = (state_q == ST_IDLE) ? req_wdata  : wdata_q;

  always_comb begin
    off   = sel_addr - BASE_ADDR;
    rword = 32'd0;
    for (int k = 0; k < 4; k++) begin
      idx[k] = AW'(off + 32'(k));
      if ((off + 32'(k)) < DEPTH_BYTES) begin
        rword[8*k +: 8] = mem_q[idx[k]];
      end
    end
  end

  lsu_align #(
    .BASE_ADDR  (BASE_ADDR),
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_align (
    .we_i    (sel_we),
    .funct3_i(sel_f3),
    .addr_i  (sel_addr),
    .rword_i (rword),
    .fault_o (fault),
    .be_o    (be),
    .rdata_o (ext_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_IDLE && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (enter_resp) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= fault;
        rsp_rdata_q <= (fault || sel_we) ? 32'd0 : ext_rdata;
        if (fault && !(&err_q)) err_q <= err_q + 1'b1;
      end else if (state_q == ST_RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  // Gated by rst_n so a store caught by reset never reaches the array.
  assign mem_wr = enter_resp && sel_we && !fault && rst_n;

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem_q[idx[k]] <= sel_wdata[8*k +: 8];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_lsu_mem.sv
// Scoreboarded random/directed bench for lsu_mem: instance 0 uses defaults,
// instance 1 uses WAIT_STATES=3 and a 2-bit fault counter.
module tb_lsu_mem;
  localparam logic [31:0] BASE  = 32'h0020_0000;
  localparam logic [31:0] DEPTH = 32'h0005_0000;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] ecnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [2:0]  req_funct3[2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic [7:0]  ec0;
  logic [1:0]  ec1;
  logic [31:0] ecnt      [2];

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] mm [longint unsigned];
  int unsigned ecnt_m [2];

  always #5 clk = ~clk;

  assign ecnt[0] = {24'd0, ec0};
  assign ecnt[1] = {30'd0, ec1};

  lsu_mem u_d0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .err_count(ec0)
  );

  lsu_mem #(.WAIT_STATES(3), .ERRCNT_W(2)) u_d1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .err_count(ec1)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model straight from the access rules: sizes, legality, bounds, little-endian bytes.
  function automatic exp_t model(input int i, input bit we, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int size;
    bit legal, mis, rng;
    longint unsigned raw;
    longint unsigned key;
    size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mis = (size == 2 && a % 2 != 0) || (size == 4 && a % 4 != 0);
    rng = (longint'(a) < longint'(BASE)) ||
          (longint'(a) + size > longint'(BASE) + longint'(DEPTH));
    e.rdata = 32'd0;
    e.err   = 1'b0;
    if (!legal || mis || rng) begin
      e.err = 1'b1;
      if (ecnt_m[i] < ((i == 0) ? 255 : 3)) ecnt_m[i]++;
    end else if (we) begin
      for (int k = 0; k < size; k++) begin
        key = (longint'(i) << 32) + longint'(a) + k;
        mm[key] = 8'((wd >> (8 * k)) & 32'hFF);
      end
    end else begin
      raw = 0;
      for (int k = 0; k < size; k++) begin
        key = (longint'(i) << 32) + longint'(a) + k;
        raw = raw + (longint'(mm[key]) << (8 * k));
      end
      if (f3 == 3'd0 && raw >= 128)   raw = raw + 64'hFFFF_FF00;
      if (f3 == 3'd1 && raw >= 32768) raw = raw + 64'hFFFF_0000;
      e.rdata = 32'(raw);
    end
    e.ecnt = ecnt_m[i];
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (rst_n[i] && rsp_valid[i] && rsp_ready[i]) begin
        if ((i == 0 ? q0.size() : q1.size()) == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
          check(i == 0 ? "rdata0" : "rdata1", rsp_rdata[i], e.rdata);
          check(i == 0 ? "err0" : "err1", {31'd0, rsp_err[i]}, {31'd0, e.err});
          check(i == 0 ? "errcnt0" : "errcnt1", ecnt[i], e.ecnt);
        end
      end
    end
  end

  // Called #1 after a posedge with the instance idle.
  task automatic do_req(input int i, input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int hold);
    exp_t e;
    int n;
    logic [31:0] r0;
    e = model(i, we, f3, a, wd);
    if (i == 0) q0.push_back(e); else q1.push_back(e);
    req_valid[i] = 1'b1; req_we[i] = we; req_funct3[i] = f3;
    req_addr[i] = a; req_wdata[i] = wd;
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    n = 1;
    while (!rsp_valid[i] && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("latency", n, (i == 0) ? 32'd1 : 32'd4);
    r0 = rsp_rdata[i];
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, rsp_valid[i]}, 32'd1);
      check("hold_rdata", rsp_rdata[i], r0);
      check("hold_req_ready", {31'd0, req_ready[i]}, 32'd0);
    end
    rsp_ready[i] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[i] = 1'b0;
    check("post_valid", {31'd0, rsp_valid[i]}, 32'd0);
    check("post_req_ready", {31'd0, req_ready[i]}, 32'd1);
  endtask

  task automatic rand_req(input int i);
    logic [31:0] a;
    int sel;
    sel = $urandom_range(0, 19);
    case (sel)
      0:       a = BASE - 32'd1;
      1:       a = BASE + DEPTH;
      2:       a = 32'hFFFF_FFFD;
      default: a = BASE + $urandom_range(0, 63);
    endcase
    do_req(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom(),
           $urandom_range(0, 2));
  endtask

  task automatic init_region(input int i);
    for (int w = 0; w < 16; w++) do_req(i, 1'b1, 3'd2, BASE + 32'(4 * w), $urandom(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_funct3[i] = 3'd0;
      req_addr[i] = 32'd0; req_wdata[i] = 32'd0; rsp_ready[i] = 1'b0; ecnt_m[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_req_ready", {31'd0, req_ready[i]}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid[i]}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata[i], 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err[i]}, 32'd0);
      check("rst_err_count", ecnt[i], 32'd0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk); #1;

    init_region(0);
    do_req(0, 1'b1, 3'd2, BASE + 32'h10, 32'hDEAD_BEEF, 0);
    do_req(0, 1'b0, 3'd2, BASE + 32'h10, 32'd0, 0);
    do_req(0, 1'b1, 3'd0, BASE + 32'h21, 32'h0000_0080, 0);
    do_req(0, 1'b0, 3'd0, BASE + 32'h21, 32'd0, 0);
    do_req(0, 1'b0, 3'd4, BASE + 32'h21, 32'd0, 0);
    do_req(0, 1'b0, 3'd1, BASE + 32'h20, 32'd0, 0);
    do_req(0, 1'b0, 3'd2, BASE + 32'h02, 32'd0, 0);
    do_req(0, 1'b1, 3'd1, BASE + 32'h03, 32'h1234_5678, 0);
    do_req(0, 1'b0, 3'd2, 32'h001F_FFFC, 32'd0, 0);
    do_req(0, 1'b1, 3'd2, 32'h0024_FFFE, 32'hCAFE_F00D, 1);
    check("errcnt_after_faults", ecnt[0], 32'd4);
    do_req(0, 1'b0, 3'd2, BASE, 32'd0, 0);
    do_req(0, 1'b0, 3'd2, BASE + 32'h20, 32'd0, 0);
    do_req(0, 1'b1, 3'd2, 32'h0024_FFFC, 32'h0BAD_CAFE, 0);
    do_req(0, 1'b0, 3'd2, 32'h0024_FFFC, 32'd0, 0);
    do_req(0, 1'b0, 3'd5, 32'hFFFF_FFFE, 32'd0, 0);
    do_req(0, 1'b1, 3'd3, BASE + 32'h08, 32'd0, 0);
    for (int n = 0; n < 150; n++) rand_req(0);

    init_region(1);
    do_req(1, 1'b0, 3'd2, BASE + 32'h08, 32'd0, 5);
    // Store abandoned by reset while in WAIT.
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = 3'd2;
    req_addr[1] = BASE + 32'h0C; req_wdata[1] = 32'h5555_AAAA;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    check("wait_req_ready", {31'd0, req_ready[1]}, 32'd0);
    rst_n[1] = 1'b0;
    #1;
    check("arst_req_ready", {31'd0, req_ready[1]}, 32'd1);
    check("arst_rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
    check("arst_rsp_rdata", rsp_rdata[1], 32'd0);
    check("arst_err_count", ecnt[1], 32'd0);
    ecnt_m[1] = 0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    @(posedge clk); #1;
    do_req(1, 1'b0, 3'd2, BASE + 32'h0C, 32'd0, 0);
    for (int n = 0; n < 5; n++) do_req(1, 1'b0, 3'd2, BASE + 32'h01, 32'd0, 0);
    check("errcnt_saturated", ecnt[1], 32'd3);
    for (int n = 0; n < 100; n++) rand_req(1);

    repeat (2) @(posedge clk);
    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
